// File: rtl/audio_sd_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma audio DAC.
// SD_DAC_ORDER2_EN selects the second-order modulator build.
package audio_sd_pkg;

    localparam int GAIN_MAX = 16;
    localparam int GAIN_W   = 5;

    typedef enum logic {
        SD_ORDER1 = 1'b0,
        SD_ORDER2 = 1'b1
    } sd_order_t;

`ifdef SD_DAC_ORDER2_EN
    localparam sd_order_t SD_ORDER = SD_ORDER2;
`else
    localparam sd_order_t SD_ORDER = SD_ORDER1;
`endif

    function automatic int unsigned mid(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sd_mod_ch.sv
// One channel of the delta-sigma modulator: carry-out accumulator by default,
// saturating second-order loop when SD_DAC_ORDER2_EN is defined.
module sd_mod_ch
    import audio_sd_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] lvl,
    output logic             pdm
);

`ifdef SD_DAC_ORDER2_EN
    localparam int SW = WIDTH + 4;
    localparam int EW = WIDTH + 6;
    localparam logic signed [EW-1:0] MID_S = EW'(mid(WIDTH));
    localparam logic signed [EW-1:0] S_MAX = EW'((2 ** (SW - 1)) - 1);
    localparam logic signed [EW-1:0] S_MIN = EW'(-(2 ** (SW - 1)));

    logic signed [SW-1:0] s1, s2, s1_next, s2_next;
    logic signed [EW-1:0] c, f, s1_sum, s2_sum;

    function automatic logic signed [SW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > S_MAX) return S_MAX[SW-1:0];
        else if (v < S_MIN) return S_MIN[SW-1:0];
        else return v[SW-1:0];
    endfunction

    always_comb begin
        c       = $signed({6'b0, lvl}) - MID_S;
        f       = pdm ? MID_S : -MID_S;
        s1_sum  = $signed({{2{s1[SW-1]}}, s1}) + c - f;
        s1_next = sat(s1_sum);
        s2_sum  = $signed({{2{s2[SW-1]}}, s2}) + $signed({{2{s1_next[SW-1]}}, s1_next}) - f;
        s2_next = sat(s2_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            pdm <= 1'b0;
        end else if (ce) begin
            s1  <= s1_next;
            s2  <= s2_next;
            pdm <= ~s2_next[SW-1];
        end
    end
`else
    // The accumulator carry is kept in pdm itself, so only the low bits are stored.
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   acc_next;

    assign acc_next = {1'b0, acc} + {1'b0, lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pdm <= 1'b0;
        end else if (ce) begin
            acc <= acc_next[WIDTH-1:0];
            pdm <= acc_next[WIDTH];
        end
    end
`endif

endmodule

// File: rtl/audio_sd_dac.sv
// Multi-channel delta-sigma audio DAC: sample latch, shared mute gain ramp and
// one modulator per channel (second order when SD_DAC_ORDER2_EN is defined).
module audio_sd_dac
    import audio_sd_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int CHANNELS  = 2,
    parameter int SIGNED_IN = 0,
    parameter int RAMP_DIV  = 64
) (
    input  logic                      clk_i,
    input  logic                      res_n_i,
    input  logic                      ce_i,
    input  logic                      sample_stb_i,
    input  logic [CHANNELS*WIDTH-1:0] dac_i,
    input  logic                      mute_i,
    output logic [CHANNELS-1:0]       dac_o,
    output logic                      muted_o
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [WIDTH-1:0]  MID      = WIDTH'(mid(WIDTH));
    localparam logic [WIDTH-1:0]  FLIP     = (SIGNED_IN != 0) ? MID : '0;
    localparam logic [GAIN_W-1:0] G_TOP    = GAIN_W'(GAIN_MAX);

    logic [GAIN_W-1:0] gain;
    logic [CNT_W-1:0]  ramp_cnt;
    logic [WIDTH-1:0]  smp [CHANNELS];

    // Samples reset to midscale so power-up fades in from silence.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            for (int n = 0; n < CHANNELS; n++) smp[n] <= MID;
        end else if (sample_stb_i) begin
            for (int n = 0; n < CHANNELS; n++) smp[n] <= dac_i[n*WIDTH +: WIDTH] ^ FLIP;
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            gain     <= '0;
            ramp_cnt <= '0;
        end else if (ce_i) begin
            if (ramp_cnt == CNT_LAST) begin
                ramp_cnt <= '0;
                if (mute_i) begin
                    if (gain != '0) gain <= gain - 1'b1;
                end else if (gain != G_TOP) begin
                    gain <= gain + 1'b1;
                end
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end

    assign muted_o = (gain == '0);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic signed [WIDTH+5:0] diff, prod;
        logic [WIDTH-1:0]        lvl;

        // Scaling around midscale keeps lvl inside 0..2^WIDTH-1 for any gain <= 16.
        assign diff = $signed({6'b0, smp[n]}) - $signed({6'b0, MID});
        assign prod = diff * $signed({{(WIDTH + 1){1'b0}}, gain});
        assign lvl  = WIDTH'($signed({6'b0, MID}) + (prod >>> 4));

        sd_mod_ch #(.WIDTH(WIDTH)) u_mod (
            .clk   (clk_i),
            .rst_n (res_n_i),
            .ce    (ce_i),
            .lvl   (lvl),
            .pdm   (dac_o[n])
        );
    end

endmodule

// File: tb/tb_audio_sd_dac.sv
// Bench for audio_sd_dac: an unsigned and a signed instance driven in lockstep and
// compared every cycle against an integer-arithmetic model, plus DC-duty vector table.
module tb_audio_sd_dac;

    localparam int W   = 10;
    localparam int CH  = 2;
    localparam int RD  = 4;
    localparam int MID = 512;

    logic clk = 1'b0;
    logic res_n = 1'b1;
    logic ce = 1'b0, stb = 1'b0, mute = 1'b0;
    logic [CH*W-1:0] din_u = '0, din_s = '0;
    logic [CH-1:0] dac_u, dac_s;
    logic muted_u, muted_s;

    always #5 clk = ~clk;

    audio_sd_dac #(.WIDTH(W), .CHANNELS(CH), .SIGNED_IN(0), .RAMP_DIV(RD)) dut_u (
        .clk_i(clk), .res_n_i(res_n), .ce_i(ce), .sample_stb_i(stb),
        .dac_i(din_u), .mute_i(mute), .dac_o(dac_u), .muted_o(muted_u)
    );

    audio_sd_dac #(.WIDTH(W), .CHANNELS(CH), .SIGNED_IN(1), .RAMP_DIV(RD)) dut_s (
        .clk_i(clk), .res_n_i(res_n), .ce_i(ce), .sample_stb_i(stb),
        .dac_i(din_s), .mute_i(mute), .dac_o(dac_s), .muted_o(muted_s)
    );

    // Reference model state: gain, ramp tick count, per-instance samples and phase.
    int   m_g, m_cnt;
    int   m_smp   [2][CH];
    int   m_phase [2][CH];
    logic m_bit   [2][CH];
    logic [10:0] exp_q[$];
    int checks, errors;

`ifdef SD_DAC_ORDER2_EN
    localparam logic [10:0] CMP_MASK = 11'b110_0001_1111;
    localparam int N_WIN = 4096;
    localparam int TOL   = 8;
`else
    localparam logic [10:0] CMP_MASK = 11'b111_1111_1111;
    localparam int N_WIN = 1024;
    localparam int TOL   = 0;
`endif

    typedef struct {
        logic [W-1:0] u_smp;
        logic [W-1:0] s_smp;
        int           u_ones;
        int           s_ones;
    } vec_t;

    vec_t vecs[4];
    int   n_vecs;

    function automatic int lvl_of(input int u, input int g);
        int d;
        d = (u - MID) * g;
        if (d >= 0) return MID + d / 16;
        return MID - ((-d + 15) / 16);
    endfunction

    function automatic int conv(input int inst, input int x);
        if (inst == 0) return x;
        return (x + MID) % 1024;
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic model_reset();
        m_g = 0;
        m_cnt = 0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                m_smp[d][c] = MID;
                m_phase[d][c] = 0;
                m_bit[d][c] = 1'b0;
            end
        exp_q.delete();
    endtask

    task automatic model_tick();
        int lv [2][CH];
        int sum;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) lv[d][c] = lvl_of(m_smp[d][c], m_g);
        if (ce) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < CH; c++) begin
                    sum = m_phase[d][c] + lv[d][c];
                    m_bit[d][c] = (sum >= 1024);
                    m_phase[d][c] = sum % 1024;
                end
            m_cnt++;
            if (m_cnt == RD) begin
                m_cnt = 0;
                if (mute) m_g = (m_g > 0) ? m_g - 1 : 0;
                else m_g = (m_g < 16) ? m_g + 1 : 16;
            end
        end
        if (stb) begin
            for (int c = 0; c < CH; c++) begin
                m_smp[0][c] = conv(0, int'(din_u[c*W +: W]));
                m_smp[1][c] = conv(1, int'(din_s[c*W +: W]));
            end
        end
        exp_q.push_back({m_g == 0, m_g == 0, m_bit[0][1], m_bit[0][0],
                         m_bit[1][1], m_bit[1][0], 5'(m_g)});
    endtask

    task automatic compare_cycle();
        logic [10:0] exp, act;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cycle_queue actual empty expected entry");
            return;
        end
        exp = exp_q.pop_front();
        act = {muted_u, muted_s, dac_u, dac_s, dut_u.gain};
        if ((act & CMP_MASK) !== (exp & CMP_MASK)) begin
            errors++;
            $display("FAIL cycle_model actual %h expected %h (muted_u,muted_s,dac_u,dac_s,gain)",
                     act & CMP_MASK, exp & CMP_MASK);
        end
    endtask

    task automatic step(input logic c, input logic s, input logic m);
        @(negedge clk);
        ce = c;
        stb = s;
        mute = m;
        @(posedge clk);
        model_tick();
        #1 compare_cycle();
    endtask

    task automatic ticks(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce = 1'b0;
        stb = 1'b0;
        #2 res_n = 1'b0;
        #1;
        check_eq("reset_muted_u", int'(muted_u), 1);
        check_eq("reset_muted_s", int'(muted_s), 1);
        check_eq("reset_dac_u", int'(dac_u), 0);
        check_eq("reset_dac_s", int'(dac_s), 0);
        check_eq("reset_gain", int'(dut_u.gain), 0);
        model_reset();
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        int cu0, cu1, cs0, cs1;
        logic mute_r;
        checks = 0;
        errors = 0;

`ifdef SD_DAC_ORDER2_EN
        vecs[0] = '{u_smp: 10'd100, s_smp: 10'h264, u_ones: 400,  s_ones: 400};
        vecs[1] = '{u_smp: 10'd512, s_smp: 10'h000, u_ones: 2048, s_ones: 2048};
        vecs[2] = '{u_smp: 10'd900, s_smp: 10'h184, u_ones: 3600, s_ones: 3600};
        n_vecs = 3;
`else
        vecs[0] = '{u_smp: 10'd256,  s_smp: 10'h000, u_ones: 256,  s_ones: 512};
        vecs[1] = '{u_smp: 10'd0,    s_smp: 10'h1FF, u_ones: 0,    s_ones: 1023};
        vecs[2] = '{u_smp: 10'd1023, s_smp: 10'h200, u_ones: 1023, s_ones: 0};
        vecs[3] = '{u_smp: 10'd512,  s_smp: 10'h100, u_ones: 512,  s_ones: 768};
        n_vecs = 4;
`endif

        do_reset();

        // Ramp-in from silence with a tick every cycle.
        ticks(3, 1'b0);
        check_eq("ramp_in_still_muted", int'(muted_u), 1);
        ticks(1, 1'b0);
        check_eq("ramp_in_unmuted", int'(muted_u), 0);
        check_eq("ramp_in_gain1", int'(dut_u.gain), 1);
        ticks(60, 1'b0);
        check_eq("ramp_in_full", int'(dut_u.gain), 16);

        // Strobe coincident with a tick: that tick still runs on the old sample.
        din_u = {CH{10'd0}};
        din_s = {CH{10'h200}};
        step(1'b0, 1'b1, 1'b0);
        ticks(8, 1'b0);
        din_u = {CH{10'd1023}};
        din_s = {CH{10'h1FF}};
        step(1'b1, 1'b1, 1'b0);
`ifndef SD_DAC_ORDER2_EN
        check_eq("coincident_old_u", int'(dac_u), 0);
        check_eq("coincident_old_s", int'(dac_s), 0);
`endif
        ticks(4, 1'b0);

        // DC duty table at full gain.
        for (int v = 0; v < n_vecs; v++) begin
            din_u = {CH{vecs[v].u_smp}};
            din_s = {CH{vecs[v].s_smp}};
            step(1'b0, 1'b1, 1'b0);
            ticks(256, 1'b0);
            cu0 = 0; cu1 = 0; cs0 = 0; cs1 = 0;
            for (int i = 0; i < N_WIN; i++) begin
                step(1'b1, 1'b0, 1'b0);
                cu0 += int'(dac_u[0]);
                cu1 += int'(dac_u[1]);
                cs0 += int'(dac_s[0]);
                cs1 += int'(dac_s[1]);
            end
            check_near($sformatf("duty_u0_v%0d", v), cu0, vecs[v].u_ones, TOL);
            check_near($sformatf("duty_u1_v%0d", v), cu1, vecs[v].u_ones, TOL);
            check_near($sformatf("duty_s0_v%0d", v), cs0, vecs[v].s_ones, TOL);
            check_near($sformatf("duty_s1_v%0d", v), cs1, vecs[v].s_ones, TOL);
        end

        // Mute mid-ramp, reverse, then a complete fade.
        do_reset();
        din_u = {CH{10'd1000}};
        din_s = {CH{10'd50}};
        step(1'b0, 1'b1, 1'b0);
        ticks(32, 1'b0);
        check_eq("midramp_gain8", int'(dut_u.gain), 8);
        ticks(12, 1'b1);
        check_eq("midramp_gain5", int'(dut_u.gain), 5);
        check_eq("midramp_not_muted", int'(muted_u), 0);
        ticks(43, 1'b0);
        check_eq("reramp_gain15", int'(dut_u.gain), 15);
        ticks(1, 1'b0);
        check_eq("reramp_gain16", int'(dut_u.gain), 16);
        ticks(63, 1'b1);
        check_eq("fade_not_yet_muted", int'(muted_u), 0);
        ticks(1, 1'b1);
        check_eq("fade_muted", int'(muted_u), 1);
        check_eq("fade_muted_s", int'(muted_s), 1);

        // Randomised ticks, strobes, samples and mute toggles.
        mute_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            din_u = 20'($urandom);
            din_s = 20'($urandom);
            if ($urandom_range(0, 40) == 0) mute_r = ~mute_r;
            step(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, mute_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sd_dac.md
# audio_sd_dac

Multi-channel delta-sigma audio DAC, the parametrised successor to the single-channel 10-bit `dac` used at core top level. It converts CHANNELS unsigned or signed PCM samples of WIDTH bits into 1-bit pulse-density outputs for the board's audio pins. It adds a strobed sample latch, a modulator clock enable, and a click-free mute gain ramp. An optional second-order modulator is also available. It sits between the core's sound generator and `AUDIO_L`/`AUDIO_R`.

## Interface
- WIDTH, 10, sample width per channel, 4..16.
- CHANNELS, 2, number of independent channels, 1..8.
- SIGNED_IN, 0, 1 = two's-complement input, 0 = offset-binary input.
- RAMP_DIV, 64, ce_i ticks per gain step, at least 1.
- clk_i  in  1  system clock (clk_sys).
- res_n_i  in  1  reset; asynchronous, active-low.
- ce_i  in  1  modulator update enable, one-cycle pulse.
- sample_stb_i  in  1  latch all channels of dac_i.
- dac_i  in  CHANNELS*WIDTH  packed samples; channel n at [n*WIDTH +: WIDTH].
- mute_i  in  1  level; request ramp to midscale.
- dac_o  out  CHANNELS  1-bit PDM outputs, registered.
- muted_o  out  1  high while gain == 0.

## Operation
- Input conversion: if SIGNED_IN, invert sample MSB (u = x ^ 2^(WIDTH-1)); otherwise u = x. Latch all channels into `smp[n]` on sample_stb_i.
- Gain stage: 5-bit gain g in 0..16, shared by all channels.
  - Per-channel level: lvl = mid + (((u − mid) * g) >>> 4), with mid = 2^(WIDTH-1).
  - Signed arithmetic is WIDTH+6 bits and the shift is arithmetic; lvl stays within 0..2^WIDTH−1 by construction.
- Ramp: ramp_cnt counts ce_i ticks from 0 to RAMP_DIV−1. On wrap:
  - if mute_i, g decrements toward 0;
  - otherwise g increments toward 16;
  - g saturates at both ends, and ramp_cnt keeps counting.
- First-order modulator, per channel: acc is WIDTH+1 bits. On ce_i, acc <= {1'b0, acc[WIDTH-1:0]} + lvl, and dac_o[n] <= acc_next[WIDTH] (the carry).
  - Long-run duty = lvl / 2^WIDTH.
  - lvl = 0 gives constant 0. lvl = 2^WIDTH−1 gives one 0 per 2^WIDTH ticks.
- Between ce_i pulses, all state and dac_o hold.

## Timing
- Reset state:
  - dac_o = 0, muted_o = 1;
  - g = 0, ramp_cnt = 0, acc = 0;
  - smp[n] = mid, so power-up ramps in from silence.
- Latch latency: smp updates on the clk_i edge where sample_stb_i = 1. The first ce_i after that edge uses the new value.
- sample_stb_i and ce_i in the same cycle: the modulator uses the old smp and the new value takes effect on the next ce_i.
- Output latency: dac_o reflects the ce_i tick that computed it, one register after the edge.
- Mute: full fade 16 → 0 takes 16*RAMP_DIV ce_i ticks. muted_o rises on the edge where g becomes 0.
- Unmute mid-ramp: the ramp reverses from the current g, with no jump.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.

## Configuration
- SD_DAC_ORDER2_EN defined: each channel uses a second-order modulator instead of first-order.
  - Centred input c = lvl − mid.
  - Feedback f = dac_o[n] ? +mid : −mid.
  - Two signed WIDTH+4-bit integrators, saturating, updated on ce_i: s1 <= s1 + c − f, then s2 <= s2 + s1_next − f.
  - dac_o[n] <= (s2_next >= 0).
  - Reset: s1 = s2 = 0.
- Undefined: first-order carry modulator only; no s1/s2 registers.
- All other behaviour is identical in both builds.

## Structure
- Package `audio_sd_pkg`: gain constants (GAIN_MAX = 16, GAIN_W = 5), the `sd_order_t` enum, and a `mid()` function.
- Sub-module `sd_mod_ch` holds one channel's modulator, instantiated CHANNELS times via generate. The gain, ramp and latch logic stays in the top of the block.

## Test plan
- Reset and ramp-in, WIDTH=10, CHANNELS=2, RAMP_DIV=4, mute_i=0, ce_i every cycle: muted_o = 1 at reset, falls after 4 ticks, g reaches 16 after 64 ticks.
- DC duty, first-order build, g=16:
  - latch 256 → exactly 256 ones in every 1024-tick window;
  - latch 0 → dac_o constant 0.
- Signed input, SIGNED_IN=1: latch 0x000 → 512 ones per 1024 ticks; latch 0x1FF → 1023 ones per 1024 ticks.
- Mute mid-ramp: assert mute_i when g = 8, deassert after 3 steps → g goes 8→5 then climbs back to 16 with no discontinuity; channel 0 lvl is monotone toward mid.
- Coincident strobe: sample_stb_i and ce_i in the same cycle → that tick's acc update uses the old sample.
- SD_DAC_ORDER2_EN: sweep constant lvl = 100, 512, 900 → measured duty within ±1 of lvl/1024 over 4096 ticks; no saturation at lvl = 1023.
